if_id_stall_ctrl: RTL and testbench
===================================

Name: if_id_stall_ctrl

Overview:
- Consumer of the hazard units' stall requests. Owns the PC register and the IF/ID pipeline register, and generates the ID/EX bubble flag.
- Applies load-use and branch-operand stalls by holding PC and IF/ID.
- Applies taken-branch redirects by loading the target and flushing IF/ID to NOP.
- A watchdog halts the front end and flags an error if a stall persists beyond a bound.

Parameters:
- PC_W, 32, PC and branch-target width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- MAX_STALL, 4, maximum consecutive stall cycles allowed before HALT.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hz_data_req  in  1  load-use bubble request from the data hazard unit.
- hz_ctrl_req  in  1  branch-operand bubble request from the control hazard unit.
- br_taken  in  1  branch/jump in ID resolved taken this cycle.
- br_target  in  PC_W  redirect address; valid when br_taken=1.
- imem_instr  in  32  instruction fetched at pc this cycle.
- pc  out  PC_W  current fetch address, registered.
- if_id_instr  out  32  IF/ID instruction, registered; 0 = NOP.
- if_id_pc4  out  PC_W  IF/ID PC+4, registered.
- id_ex_bubble  out  1  registered; 1 = instruction now entering EX is a bubble (control zeroed).
- stall_active  out  1  registered; 1 while state is STALL or HALT.
- stall_err  out  1  sticky; 1 once HALT is entered.

Behaviour:
- Derived signal: stall_req = hz_data_req | hz_ctrl_req.
- Reset (sync, rst=1 at edge), overrides everything including mid-stall and HALT:
  - pc=RESET_PC, if_id_instr=0, if_id_pc4=0.
  - id_ex_bubble=1, stall_active=0, stall_err=0.
  - stall_cnt=0, state=RUN.
- States: RUN, STALL, HALT. Encoding is free.
- Priority per edge, in RUN or STALL: stall_req > br_taken > sequential. br_taken is ignored whenever stall_req=1.
- Stall (stall_req=1):
  - pc, if_id_instr and if_id_pc4 hold.
  - id_ex_bubble<=1; stall_cnt<=stall_cnt+1; state<=STALL; stall_active<=1.
  - This replaces PC-rewind: PC is never decremented.
- Redirect (stall_req=0, br_taken=1):
  - pc<={br_target[PC_W-1:2],2'b00}.
  - if_id_instr<=0 and if_id_pc4<=0 (flush the wrong-path fetch).
  - id_ex_bubble<=0; stall_cnt<=0; state<=RUN; stall_active<=0.
- Sequential (stall_req=0, br_taken=0):
  - pc<=pc+4, wrapping modulo 2^PC_W (0xFFFF_FFFC -> 0).
  - if_id_instr<=imem_instr; if_id_pc4<=pc+4 (wrapped).
  - id_ex_bubble<=0; stall_cnt<=0; state<=RUN; stall_active<=0.
- Watchdog:
  - Condition: stall_req=1 while stall_cnt==MAX_STALL, i.e. the (MAX_STALL+1)th consecutive stalled cycle.
  - Action: state<=HALT, stall_err<=1.
  - Exactly MAX_STALL consecutive stall cycles are legal.
- HALT:
  - pc and IF/ID frozen; id_ex_bubble=1; stall_active=1; stall_err=1.
  - All inputs ignored; only rst exits.
- stall_cnt width is clog2(MAX_STALL+1); it saturates at MAX_STALL.
- Latency:
  - A request sampled at edge N gives a held pc and id_ex_bubble=1 from edge N onward.
  - The release cycle advances pc at the next edge.
  - No combinational path from inputs to outputs.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[CNT_W-1:0], incremented on every stall-edge in RUN/STALL.
  - Adds flush_count[CNT_W-1:0], incremented on every redirect edge.
  - Both saturate at all-ones, clear on rst, and freeze in HALT.
- Undefined: ports and counters are absent; remaining behaviour is identical.

Test Plan:
- rst 1 cycle, RESET_PC=0, stall_req=0, br_taken=0, imem_instr=0x11,0x22,0x33 -> pc 0,4,8,12; if_id_instr 0x11,0x22,0x33; if_id_pc4 4,8,12; id_ex_bubble 1 then 0.
- hz_data_req=1 for 1 cycle at pc=8 -> pc stays 8 for one extra cycle; if_id_instr unchanged; id_ex_bubble=1 for exactly one cycle; stall_active pulse of 1; then pc=12.
- pc=0x10, br_taken=1, br_target=0x43 -> next pc=0x40; if_id_instr=0, if_id_pc4=0; id_ex_bubble=0; following fetch from 0x40.
- hz_ctrl_req=1 and br_taken=1 (target 0x80) same cycle, next cycle br_taken=1 alone -> first edge holds pc; second edge pc=0x80.
- MAX_STALL=4: stall_req held 4 cycles then released -> stall_err=0, pc resumes. Held 5 cycles -> stall_err=1 and HALT, pc frozen despite release; rst -> pc=RESET_PC, stall_err=0.
- RESET_PC=0xFFFF_FFF8, free run -> pc 0xFFFF_FFFC then 0x0. With STALL_PERF_CNT_EN: 3 stalls + 2 redirects -> stall_cycles=3, flush_count=2.

Source files
------------

// File: rtl/if_id_stall_ctrl.sv
// if_id_stall_ctrl
// Front-end stall controller. It owns the fetch PC and the IF/ID pipeline
// register, and it produces the registered ID/EX bubble flag.
//  - A stall request (load-use or branch-operand) holds PC and IF/ID and
//    injects a bubble into EX. The PC is held, never rewound.
//  - A taken branch with no stall loads the word-aligned target and
//    flushes IF/ID to NOP.
//  - A watchdog moves to HALT on the (MAX_STALL+1)th consecutive stalled
//    edge. HALT freezes the front end and sets a sticky error; only rst
//    leaves HALT.
// Optional feature macro: STALL_PERF_CNT_EN adds saturating stall_cycles
// and flush_count performance counters. These counters freeze in HALT.
// All outputs come straight from flops, so no input reaches an output
// combinationally.

module if_id_stall_ctrl #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}},
  parameter int unsigned     MAX_STALL = 4,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hz_data_req,
  input  logic            hz_ctrl_req,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic [31:0]     imem_instr,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc4,
  output logic            id_ex_bubble,
  output logic            stall_active,
`ifdef STALL_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
`endif
  output logic            stall_err
);

  // The stall counter only needs to reach MAX_STALL, because it saturates there.
  localparam int unsigned       SCNT_W   = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(MAX_STALL);
  localparam logic [PC_W-1:0]   PC_STEP  = PC_W'(3'd4);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic [PC_W-1:0]   if_id_pc4_q, if_id_pc4_d;
  logic              id_ex_bubble_q, id_ex_bubble_d;
  logic              stall_active_q, stall_active_d;
  logic              stall_err_q, stall_err_d;

  logic              stall_req;
  logic [PC_W-1:0]   pc_plus4;
  logic [PC_W-1:0]   redirect_pc;
  logic              stall_edge;
  logic              flush_edge;

  // The redirect target is forced to word alignment, so its low two bits are dropped.
  logic              br_tgt_lo_unused;

  assign stall_req        = hz_data_req | hz_ctrl_req;
  assign pc_plus4         = pc_q + PC_STEP;
  assign redirect_pc      = {br_target[PC_W-1:2], 2'b00};
  assign br_tgt_lo_unused = ^br_target[1:0];

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction
`endif

  // Next-state logic and register updates. Priority is stall, then redirect, then sequential.
  always_comb begin
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    pc_d           = pc_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_pc4_d    = if_id_pc4_q;
    id_ex_bubble_d = id_ex_bubble_q;
    stall_active_d = stall_active_q;
    stall_err_d    = stall_err_q;
    stall_edge     = 1'b0;
    flush_edge     = 1'b0;

    case (state_q)
      ST_HALT: begin
        // In HALT the front end is frozen and every input is ignored.
        id_ex_bubble_d = 1'b1;
        stall_active_d = 1'b1;
        stall_err_d    = 1'b1;
      end
      ST_RUN, ST_STALL: begin
        if (stall_req) begin
          // Hold PC and IF/ID. Any br_taken this cycle is deliberately dropped.
          stall_edge     = 1'b1;
          id_ex_bubble_d = 1'b1;
          stall_active_d = 1'b1;
          if (stall_cnt_q == SCNT_MAX) begin
            state_d     = ST_HALT;
            stall_err_d = 1'b1;
          end else begin
            state_d     = ST_STALL;
            stall_cnt_d = stall_cnt_q + SCNT_W'(1'b1);
          end
        end else if (br_taken) begin
          // Redirect, and turn the wrong-path fetch in IF/ID into a NOP.
          flush_edge     = 1'b1;
          pc_d           = redirect_pc;
          if_id_instr_d  = 32'h0000_0000;
          if_id_pc4_d    = {PC_W{1'b0}};
          id_ex_bubble_d = 1'b0;
          stall_active_d = 1'b0;
          stall_cnt_d    = {SCNT_W{1'b0}};
          state_d        = ST_RUN;
        end else begin
          // Sequential fetch. The PC wraps naturally modulo 2^PC_W.
          pc_d           = pc_plus4;
          if_id_instr_d  = imem_instr;
          if_id_pc4_d    = pc_plus4;
          id_ex_bubble_d = 1'b0;
          stall_active_d = 1'b0;
          stall_cnt_d    = {SCNT_W{1'b0}};
          state_d        = ST_RUN;
        end
      end
      default: begin
        // An unreachable encoding fails safe into HALT and sets the error.
        state_d        = ST_HALT;
        id_ex_bubble_d = 1'b1;
        stall_active_d = 1'b1;
        stall_err_d    = 1'b1;
      end
    endcase
  end

  // State and pipeline registers. The synchronous reset overrides every state, including HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      stall_cnt_q    <= {SCNT_W{1'b0}};
      pc_q           <= RESET_PC;
      if_id_instr_q  <= 32'h0000_0000;
      if_id_pc4_q    <= {PC_W{1'b0}};
      id_ex_bubble_q <= 1'b1;
      stall_active_q <= 1'b0;
      stall_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      pc_q           <= pc_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_pc4_q    <= if_id_pc4_d;
      id_ex_bubble_q <= id_ex_bubble_d;
      stall_active_q <= stall_active_d;
      stall_err_q    <= stall_err_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  // Next values of the saturating performance counters. They only move on RUN/STALL edges.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_edge) begin
      stall_cycles_d = sat_inc(stall_cycles_q);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (flush_edge) begin
      flush_count_d = sat_inc(flush_count_q);
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Performance counter registers, cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= {CNT_W{1'b0}};
      flush_count_q  <= {CNT_W{1'b0}};
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  // Without the counters, the edge strobes feed nothing.
  logic perf_edges_unused;
  assign perf_edges_unused = stall_edge ^ flush_edge;
`endif

  assign pc           = pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc4    = if_id_pc4_q;
  assign id_ex_bubble = id_ex_bubble_q;
  assign stall_active = stall_active_q;
  assign stall_err    = stall_err_q;

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Testbench for if_id_stall_ctrl. Directed scenarios followed by random
// bursts, all checked against a behavioural front-end model.
module tb_if_id_stall_ctrl;
  localparam int MAX_STALL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hz_data_req = 1'b0, hz_ctrl_req = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = 32'h0, imem_instr = 32'h0;
  logic [31:0] pc, if_id_instr, if_id_pc4;
  logic        id_ex_bubble, stall_active, stall_err;
`ifdef STALL_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model of the front end.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_bub, m_act, m_err, m_halt;
  int          m_run;
  int          m_sc, m_fc;

  always #5 clk = ~clk;

  if_id_stall_ctrl #(.PC_W(32), .RESET_PC(32'h0000_0000), .MAX_STALL(MAX_STALL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hz_data_req(hz_data_req), .hz_ctrl_req(hz_ctrl_req),
    .br_taken(br_taken), .br_target(br_target), .imem_instr(imem_instr),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .id_ex_bubble(id_ex_bubble), .stall_active(stall_active),
`ifdef STALL_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .stall_err(stall_err)
  );

  // Apply one cycle of inputs. Advance the model on the edge, then settle for sampling.
  task automatic drive(input logic r, input logic d, input logic c, input logic b,
                       input logic [31:0] t, input logic [31:0] im);
    rst = r; hz_data_req = d; hz_ctrl_req = c; br_taken = b; br_target = t; imem_instr = im;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_bub = 1'b1; m_act = 1'b0;
      m_err = 1'b0; m_halt = 1'b0; m_run = 0; m_sc = 0; m_fc = 0;
    end else if (!m_halt) begin
      if (d || c) begin
        if (m_sc < 65535) m_sc++;
        if (m_run == MAX_STALL) begin m_halt = 1'b1; m_err = 1'b1; end
        else m_run++;
        m_bub = 1'b1; m_act = 1'b1;
      end else if (b) begin
        m_pc = t & 32'hFFFF_FFFC; m_instr = 32'h0; m_pc4 = 32'h0;
        m_bub = 1'b0; m_act = 1'b0; m_run = 0;
        if (m_fc < 65535) m_fc++;
      end else begin
        m_pc = m_pc + 32'd4; m_instr = im; m_pc4 = m_pc;
        m_bub = 1'b0; m_act = 1'b0; m_run = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total += 6;
    if (pc !== 32'h0)           begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
    if (if_id_instr !== 32'h0)  begin bad++; $display("FAIL reset_instr got=%h exp=0", if_id_instr); end
    if (if_id_pc4 !== 32'h0)    begin bad++; $display("FAIL reset_pc4 got=%h exp=0", if_id_pc4); end
    if (id_ex_bubble !== 1'b1)  begin bad++; $display("FAIL reset_bubble got=%b exp=1", id_ex_bubble); end
    if (stall_active !== 1'b0)  begin bad++; $display("FAIL reset_active got=%b exp=0", stall_active); end
    if (stall_err !== 1'b0)     begin bad++; $display("FAIL reset_err got=%b exp=0", stall_err); end
  endtask

  task automatic test_sequential();
    logic [31:0] ins [3];
    ins[0] = 32'h11; ins[1] = 32'h22; ins[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, ins[i]);
      total += 4;
      if (pc !== 32'(4 * (i + 1))) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, 4 * (i + 1)); end
      if (if_id_instr !== ins[i])  begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, if_id_instr, ins[i]); end
      if (if_id_pc4 !== 32'(4 * (i + 1))) begin bad++; $display("FAIL seq_pc4[%0d] got=%h exp=%h", i, if_id_pc4, 4 * (i + 1)); end
      if (id_ex_bubble !== 1'b0)   begin bad++; $display("FAIL seq_bubble[%0d] got=%b exp=0", i, id_ex_bubble); end
    end
  endtask

  task automatic test_stall_pulse();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h11);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h22);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h99);
    total += 4;
    if (pc !== 32'h8)            begin bad++; $display("FAIL stall_hold_pc got=%h exp=8", pc); end
    if (if_id_instr !== 32'h22)  begin bad++; $display("FAIL stall_hold_instr got=%h exp=22", if_id_instr); end
    if (id_ex_bubble !== 1'b1)   begin bad++; $display("FAIL stall_bubble got=%b exp=1", id_ex_bubble); end
    if (stall_active !== 1'b1)   begin bad++; $display("FAIL stall_active got=%b exp=1", stall_active); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h33);
    total += 4;
    if (pc !== 32'hC)            begin bad++; $display("FAIL release_pc got=%h exp=c", pc); end
    if (if_id_instr !== 32'h33)  begin bad++; $display("FAIL release_instr got=%h exp=33", if_id_instr); end
    if (id_ex_bubble !== 1'b0)   begin bad++; $display("FAIL release_bubble got=%b exp=0", id_ex_bubble); end
    if (stall_active !== 1'b0)   begin bad++; $display("FAIL release_active got=%b exp=0", stall_active); end
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h44);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h43, 32'hAA);
    total += 4;
    if (pc !== 32'h40)           begin bad++; $display("FAIL redir_pc got=%h exp=40", pc); end
    if (if_id_instr !== 32'h0)   begin bad++; $display("FAIL redir_flush_instr got=%h exp=0", if_id_instr); end
    if (if_id_pc4 !== 32'h0)     begin bad++; $display("FAIL redir_flush_pc4 got=%h exp=0", if_id_pc4); end
    if (id_ex_bubble !== 1'b0)   begin bad++; $display("FAIL redir_bubble got=%b exp=0", id_ex_bubble); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h55);
    total += 2;
    if (if_id_instr !== 32'h55)  begin bad++; $display("FAIL redir_fetch_instr got=%h exp=55", if_id_instr); end
    if (if_id_pc4 !== 32'h44)    begin bad++; $display("FAIL redir_fetch_pc4 got=%h exp=44", if_id_pc4); end
  endtask

  task automatic test_stall_vs_branch();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h66);
    total += 2;
    if (pc !== 32'h44)           begin bad++; $display("FAIL stallbr_hold_pc got=%h exp=44", pc); end
    if (if_id_instr !== 32'h55)  begin bad++; $display("FAIL stallbr_hold_instr got=%h exp=55", if_id_instr); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h66);
    total += 1;
    if (pc !== 32'h80)           begin bad++; $display("FAIL stallbr_redir_pc got=%h exp=80", pc); end
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < MAX_STALL; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    total += 2;
    if (stall_err !== 1'b0)      begin bad++; $display("FAIL wd_legal_err got=%b exp=0", stall_err); end
    if (pc !== 32'h80)           begin bad++; $display("FAIL wd_legal_hold got=%h exp=80", pc); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h7);
    total += 2;
    if (pc !== 32'h84)           begin bad++; $display("FAIL wd_resume_pc got=%h exp=84", pc); end
    if (stall_err !== 1'b0)      begin bad++; $display("FAIL wd_resume_err got=%b exp=0", stall_err); end
    for (int i = 0; i < MAX_STALL + 1; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    total += 2;
    if (stall_err !== 1'b1)      begin bad++; $display("FAIL wd_halt_err got=%b exp=1", stall_err); end
    if (stall_active !== 1'b1)   begin bad++; $display("FAIL wd_halt_active got=%b exp=1", stall_active); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h9);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h9);
    total += 4;
    if (pc !== 32'h84)           begin bad++; $display("FAIL wd_frozen_pc got=%h exp=84", pc); end
    if (if_id_instr !== 32'h7)   begin bad++; $display("FAIL wd_frozen_instr got=%h exp=7", if_id_instr); end
    if (id_ex_bubble !== 1'b1)   begin bad++; $display("FAIL wd_frozen_bubble got=%b exp=1", id_ex_bubble); end
    if (stall_err !== 1'b1)      begin bad++; $display("FAIL wd_sticky_err got=%b exp=1", stall_err); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total += 3;
    if (pc !== 32'h0)            begin bad++; $display("FAIL wd_rst_pc got=%h exp=0", pc); end
    if (stall_err !== 1'b0)      begin bad++; $display("FAIL wd_rst_err got=%b exp=0", stall_err); end
    if (stall_active !== 1'b0)   begin bad++; $display("FAIL wd_rst_active got=%b exp=0", stall_active); end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1);
    total += 2;
    if (pc !== 32'hFFFF_FFFC)        begin bad++; $display("FAIL wrap_pc1 got=%h exp=fffffffc", pc); end
    if (if_id_pc4 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc4_1 got=%h exp=fffffffc", if_id_pc4); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2);
    total += 2;
    if (pc !== 32'h0)                begin bad++; $display("FAIL wrap_pc2 got=%h exp=0", pc); end
    if (if_id_pc4 !== 32'h0)         begin bad++; $display("FAIL wrap_pc4_2 got=%h exp=0", if_id_pc4); end
  endtask

`ifdef STALL_PERF_CNT_EN
  task automatic test_perf_counters();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
    total += 2;
    if (stall_cycles !== 16'd3) begin bad++; $display("FAIL perf_stalls got=%0d exp=3", stall_cycles); end
    if (flush_count !== 16'd2)  begin bad++; $display("FAIL perf_flushes got=%0d exp=2", flush_count); end
  endtask
`endif

  task automatic test_random();
    int burst;
    logic r, d, c, b;
    burst = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      if (burst == 0 && $urandom_range(0, 5) == 0) burst = $urandom_range(1, 6);
      r = ($urandom_range(0, 49) == 0);
      d = (burst > 0) && $urandom_range(0, 1) == 1;
      c = (burst > 0) && !d;
      b = ($urandom_range(0, 3) == 0);
      if (burst > 0) burst--;
      drive(r, d, c, b, $urandom, $urandom);
      total++;
      if (pc !== m_pc || if_id_instr !== m_instr || if_id_pc4 !== m_pc4 ||
          id_ex_bubble !== m_bub || stall_active !== m_act || stall_err !== m_err) begin
        bad++;
        $display("FAIL rand[%0d] got pc=%h ins=%h pc4=%h bub=%b act=%b err=%b exp pc=%h ins=%h pc4=%h bub=%b act=%b err=%b",
                 i, pc, if_id_instr, if_id_pc4, id_ex_bubble, stall_active, stall_err,
                 m_pc, m_instr, m_pc4, m_bub, m_act, m_err);
      end
`ifdef STALL_PERF_CNT_EN
      total++;
      if (stall_cycles !== 16'(m_sc) || flush_count !== 16'(m_fc)) begin
        bad++;
        $display("FAIL rand_perf[%0d] got sc=%0d fc=%0d exp sc=%0d fc=%0d", i, stall_cycles, flush_count, m_sc, m_fc);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_pulse();
    test_redirect();
    test_stall_vs_branch();
    test_watchdog();
    test_wrap();
`ifdef STALL_PERF_CNT_EN
    test_perf_counters();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
